// File: rtl/bfly_pkg.sv
// Shared constants, result record and width helper for the butterfly result collector.
package bfly_pkg;

    localparam int BITS            = 32;
    localparam int TAG_W           = 4;
    localparam int DEFAULT_LATENCY = 12;
    localparam int DEFAULT_DEPTH   = 8;

    typedef struct packed {
        logic [BITS-1:0]  re;
        logic [BITS-1:0]  im;
        logic [TAG_W-1:0] tag;
    } bfly_result_t;

    localparam int RESULT_W = $bits(bfly_result_t);

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    localparam int DEFAULT_PTR_W = clog2(DEFAULT_DEPTH);

endpackage

// File: rtl/bfly_sync_fifo.sv
// Result FIFO: DEPTH entries of bfly_result_t, head read straight from storage registers,
// occupancy exported so the collector can compute credits.
module bfly_sync_fifo
    import bfly_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic [RESULT_W-1:0] push_data,
    input  logic                pop,
    output logic [RESULT_W-1:0] head,
    output logic [CNT_W-1:0]    count
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [RESULT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && (count != FULL_COUNT);
    assign do_pop  = pop && (count != '0);

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/bfly_result_collector.sv
// Tracks operand sets through the fixed-latency butterfly and buffers the results with credits.
// Optional err_protocol/result_cnt outputs appear when BFLY_COLLECT_STATS_EN is defined.
module bfly_result_collector
    import bfly_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int DEPTH   = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             issue_ready,
    input  logic [BITS-1:0]  re_z,
    input  logic [BITS-1:0]  im_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_re,
    output logic [BITS-1:0]  out_im,
    output logic [TAG_W-1:0] out_tag
`ifdef BFLY_COLLECT_STATS_EN
    ,
    output logic             err_protocol,
    output logic [31:0]      result_cnt
`endif
);

    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    logic               issue;
    logic               last_valid;
    logic               pop;
    logic [LATENCY-1:0] dly_valid;
    logic [TAG_W-1:0]   dly_tag [LATENCY];
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credits_used;
    bfly_result_t       push_res;
    bfly_result_t       head_res;

    assign issue      = in_valid && issue_ready;
    assign last_valid = dly_valid[LATENCY-1];
    assign pop        = out_valid && out_ready;

    // Every tracked beat holds one credit from issue until it leaves the FIFO,
    // so in-flight plus buffered results can never exceed the FIFO depth.
    assign credits_used = {1'b0, inflight} + {1'b0, count};
    assign issue_ready  = credits_used < CREDIT_LIMIT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dly_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dly_tag[i] <= '0;
            end
        end else begin
            dly_valid[0] <= issue;
            dly_tag[0]   <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                dly_valid[i] <= dly_valid[i-1];
                dly_tag[i]   <= dly_tag[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({issue, last_valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign push_res.re  = re_z;
    assign push_res.im  = im_z;
    assign push_res.tag = dly_tag[LATENCY-1];

    bfly_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (last_valid),
        .push_data (push_res),
        .pop       (pop),
        .head      (head_res),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_re    = head_res.re;
    assign out_im    = head_res.im;
    assign out_tag   = head_res.tag;

`ifdef BFLY_COLLECT_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_protocol <= 1'b0;
            result_cnt   <= '0;
        end else begin
            if (in_valid && !issue_ready) begin
                err_protocol <= 1'b1;
            end
            if (pop) begin
                result_cnt <= result_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bfly_result_collector.sv
// Directed bench for bfly_result_collector: a butterfly stand-in delays operands by LATENCY,
// a scoreboard queue holds expected results and a negedge monitor checks every pop.
module tb_bfly_result_collector;
    import bfly_pkg::*;

    localparam int LAT = 12;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             issue_ready;
    logic [BITS-1:0]  re_z;
    logic [BITS-1:0]  im_z;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BITS-1:0]  out_re;
    logic [BITS-1:0]  out_im;
    logic [TAG_W-1:0] out_tag;
`ifdef BFLY_COLLECT_STATS_EN
    logic             err_protocol;
    logic [31:0]      result_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    bfly_result_t sb[$];
    bfly_result_t exp_res;

    logic [BITS-1:0] op_re = 32'hDEADBEEF;
    logic [BITS-1:0] op_im = 32'hBAADF00D;
    logic [BITS-1:0] pipe_re [LAT];
    logic [BITS-1:0] pipe_im [LAT];

    always #5 clock = ~clock;

    // Butterfly stand-in: whatever sits on the operand bus emerges LAT cycles later.
    always @(posedge clock) begin
        cyc        <= cyc + 1;
        pipe_re[0] <= op_re;
        pipe_im[0] <= op_im;
        for (int i = 1; i < LAT; i++) begin
            pipe_re[i] <= pipe_re[i-1];
            pipe_im[i] <= pipe_im[i-1];
        end
    end
    assign re_z = pipe_re[LAT-1];
    assign im_z = pipe_im[LAT-1];

    bfly_result_collector dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_tag      (in_tag),
        .issue_ready (issue_ready),
        .re_z        (re_z),
        .im_z        (im_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_tag     (out_tag)
`ifdef BFLY_COLLECT_STATS_EN
        ,
        .err_protocol (err_protocol),
        .result_cnt   (result_cnt)
`endif
    );

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [BITS-1:0] make_re(input int t);
        return 32'h4000_0000 + 32'(t);
    endfunction

    function automatic logic [BITS-1:0] make_im(input int t);
        return 32'hC100_0000 + 32'(t * 3);
    endfunction

    // Drives one cycle of operands; exp_ready is the hand-derived credit state for that cycle.
    task automatic apply_stimulus(input logic valid, input logic [TAG_W-1:0] tag,
                                  input logic [BITS-1:0] d_re, input logic [BITS-1:0] d_im,
                                  input logic exp_ready);
        check_bit("issue_ready", issue_ready, exp_ready);
        in_valid = valid;
        in_tag   = tag;
        op_re    = valid ? d_re : 32'hDEADBEEF;
        op_im    = valid ? d_im : 32'hBAADF00D;
        if (valid && exp_ready) begin
            sb.push_back('{re: d_re, im: d_im, tag: tag});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        op_re    = 32'hDEADBEEF;
        op_im    = 32'hBAADF00D;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            pops++;
            last_pop_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got tag %0d re %h, expected none", out_tag, out_re);
            end else begin
                exp_res = sb.pop_front();
                check_word("out_re", out_re, exp_res.re);
                check_word("out_im", out_im, exp_res.im);
                check_word("out_tag", 32'(out_tag), 32'(exp_res.tag));
            end
        end
    end

    initial begin
        int p0;
        int start;
        int t;

        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_issue_ready", issue_ready, 1'b1);
        check_word("reset_out_re", out_re, 32'h0);
        check_word("reset_out_im", out_im, 32'h0);
        check_word("reset_out_tag", 32'(out_tag), 32'h0);

        $display("[TB] single issue latency");
        out_ready = 1'b1;
        apply_stimulus(1'b1, 4'd3, 32'h3F800000, 32'h40000000, 1'b1);
        idle(LAT - 1);
        check_bit("out_valid_at_lat", out_valid, 1'b0);
        idle(1);
        check_bit("out_valid_at_lat1", out_valid, 1'b1);
        check_word("first_out_re", out_re, 32'h3F800000);
        check_word("first_out_tag", 32'(out_tag), 32'd3);
        idle(3);
        check_bit("single_drained", out_valid, 1'b0);

        $display("[TB] fill to full with out_ready low");
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, 4'(k), make_re(k + 16), make_im(k + 16), 1'b1);
        end
        apply_stimulus(1'b1, 4'd8, make_re(99), make_im(99), 1'b0);
        apply_stimulus(1'b1, 4'd9, make_re(98), make_im(98), 1'b0);
        idle(LAT + 4);
        check_bit("full_issue_ready", issue_ready, 1'b0);
        check_bit("full_out_valid", out_valid, 1'b1);
`ifdef BFLY_COLLECT_STATS_EN
        check_bit("err_protocol_set", err_protocol, 1'b1);
`endif

        $display("[TB] single pop from full");
        p0 = pops;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_bit("credit_after_pop", issue_ready, 1'b1);
        check_word("one_pop", 32'(pops - p0), 32'd1);
        out_ready = 1'b1;
        idle(10);
        check_bit("full_drained", out_valid, 1'b0);
        check_word("sb_empty_after_fill", 32'(sb.size()), 32'd0);

        $display("[TB] streaming tags 0..15 with out_ready high");
        p0 = pops;
        start = cyc;
        t = 0;
        for (int k = 0; k < 22; k++) begin
            logic exp_ready;
            exp_ready = (k < 8) || (k >= 14);
            apply_stimulus(1'b1, t[TAG_W-1:0], make_re(t + 32), make_im(t + 32), exp_ready);
            if (exp_ready) t++;
        end
        idle(16);
        check_word("stream_pops", 32'(pops - p0), 32'd16);
        check_word("stream_last_pop_cycle", 32'(last_pop_cyc - start), 32'd34);

        $display("[TB] reset with results in flight and buffered");
        out_ready = 1'b0;
        p0 = pops;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 4'(k + 10), make_re(k + 64), make_im(k + 64), 1'b1);
        end
        idle(13);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 4'(k), make_re(k + 80), make_im(k + 80), 1'b1);
        end
        in_valid = 1'b0;
        check_bit("pre_reset_out_valid", out_valid, 1'b1);
        check_bit("pre_reset_issue_ready", issue_ready, 1'b0);
        reset = 1'b0;
        #1;
        check_bit("async_reset_out_valid", out_valid, 1'b0);
        check_bit("async_reset_issue_ready", issue_ready, 1'b1);
        check_word("async_reset_out_re", out_re, 32'h0);
        check_word("async_reset_out_tag", 32'(out_tag), 32'h0);
        sb.delete();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
`ifdef BFLY_COLLECT_STATS_EN
        check_bit("err_protocol_cleared", err_protocol, 1'b0);
        check_word("result_cnt_cleared", result_cnt, 32'd0);
`endif
        out_ready = 1'b1;
        idle(LAT + 4);
        check_bit("no_stale_out_valid", out_valid, 1'b0);
        check_word("no_stale_pops", 32'(pops - p0), 32'd0);

        $display("[TB] ten results after reset");
        p0 = pops;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, 4'(k + 5), make_re(k + 96), make_im(k + 96), 1'b1);
        end
        idle(LAT + 10);
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b1, 4'(k + 1), make_re(k + 112), make_im(k + 112), 1'b1);
        end
        idle(LAT + 4);
        check_word("ten_pops", 32'(pops - p0), 32'd10);
`ifdef BFLY_COLLECT_STATS_EN
        check_word("result_cnt_ten", result_cnt, 32'd10);
        check_bit("err_protocol_still_clear", err_protocol, 1'b0);
`endif

        $display("[TB] protocol violation while full");
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, 4'(15 - k), make_re(k + 128), make_im(k + 128), 1'b1);
        end
        apply_stimulus(1'b1, 4'd7, make_re(200), make_im(200), 1'b0);
        idle(2);
`ifdef BFLY_COLLECT_STATS_EN
        check_bit("err_protocol_raised", err_protocol, 1'b1);
`endif
        out_ready = 1'b1;
        idle(LAT + 12);
`ifdef BFLY_COLLECT_STATS_EN
        check_bit("err_protocol_sticky", err_protocol, 1'b1);
`endif
        check_bit("final_out_valid", out_valid, 1'b0);
        check_word("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
